// File: rtl/adjust_ctrl.sv
// adjust_ctrl: adjust-mode FSM for a clock (field select, increments, blink, run gate).
// Define ADJ_TIMEOUT_EN to abandon adjust mode after TIMEOUT_SEC idle seconds.
module adjust_ctrl #(
    parameter int TIMEOUT_SEC = 30
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en1hz,
    input  logic sig2hz,
    input  logic mode,
    input  logic select,
    input  logic adjust,
    output logic sec_inc,
    output logic min_inc,
    output logic hour_inc,
    output logic sec_on,
    output logic min_on,
    output logic hour_on,
    output logic run
);
    localparam logic [1:0] NORMAL = 2'd0;
    localparam logic [1:0] SEC    = 2'd1;
    localparam logic [1:0] HOUR   = 2'd2;
    localparam logic [1:0] MIN    = 2'd3;
    localparam logic [7:0] TMO    = 8'(TIMEOUT_SEC);

    logic [1:0] state, nxt, sel_nxt;
    logic       btn, tmo_hit, adj_ok;

    assign btn    = mode | select | adjust;
    assign adj_ok = adjust & ~mode & ~select;

    always_comb sel_nxt = state == SEC ? HOUR : state == HOUR ? MIN : state == MIN ? SEC : NORMAL;

`ifdef ADJ_TIMEOUT_EN
    logic [7:0] tcnt;
    // A coinciding button clears the count, so it also cancels the hit.
    assign tmo_hit = ~btn & en1hz & (state != NORMAL) & (tcnt == TMO - 8'd1);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            tcnt <= 8'd0;
        else if (btn || nxt != state)
            tcnt <= 8'd0;
        else if (en1hz && state != NORMAL && tcnt != 8'hff)
            tcnt <= tcnt + 8'd1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^{TMO, en1hz};
    assign tmo_hit    = 1'b0;
`endif

    always_comb nxt = mode ? (state == NORMAL ? SEC : NORMAL) :
                      select ? sel_nxt :
                      adjust ? state :
                      tmo_hit ? NORMAL : state;

    // Outputs are derived from nxt so they line up with the registered state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= NORMAL;
            sec_inc  <= 1'b0;
            min_inc  <= 1'b0;
            hour_inc <= 1'b0;
            sec_on   <= 1'b1;
            min_on   <= 1'b1;
            hour_on  <= 1'b1;
            run      <= 1'b1;
        end else begin
            state    <= nxt;
            sec_inc  <= adj_ok && state == SEC;
            min_inc  <= adj_ok && state == MIN;
            hour_inc <= adj_ok && state == HOUR;
            sec_on   <= nxt != SEC || sig2hz;
            min_on   <= nxt != MIN || sig2hz;
            hour_on  <= nxt != HOUR || sig2hz;
            run      <= nxt != SEC;
        end
    end
endmodule

// File: tb/tb_adjust_ctrl.sv
// tb_adjust_ctrl: directed self-checking bench for adjust_ctrl (TIMEOUT_SEC=3).
module tb_adjust_ctrl;
    logic clk = 1'b0, n_rst = 1'b0;
    logic en1hz = 1'b0, sig2hz = 1'b0, mode = 1'b0, select = 1'b0, adjust = 1'b0;
    logic sec_inc, min_inc, hour_inc, sec_on, min_on, hour_on, run;
    int n_pass = 0, n_total = 0;
    int n_sec = 0, n_min = 0, n_hour = 0;

    localparam logic [3:0] V_NORMAL = 4'b1111;
    localparam logic [3:0] V_SEC    = 4'b0110;
    localparam logic [3:0] V_HOUR   = 4'b1101;
    localparam logic [3:0] V_MIN    = 4'b1011;

    adjust_ctrl #(.TIMEOUT_SEC(3)) dut (
        .clk(clk), .n_rst(n_rst), .en1hz(en1hz), .sig2hz(sig2hz),
        .mode(mode), .select(select), .adjust(adjust),
        .sec_inc(sec_inc), .min_inc(min_inc), .hour_inc(hour_inc),
        .sec_on(sec_on), .min_on(min_on), .hour_on(hour_on), .run(run)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (n_rst) begin
            n_sec  += int'(sec_inc);
            n_min  += int'(min_inc);
            n_hour += int'(hour_inc);
        end
    end

    function automatic logic [3:0] vec();
        return {sec_on, min_on, hour_on, run};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input logic m, input logic s, input logic a, input logic e);
        @(negedge clk);
        mode = m; select = s; adjust = a; en1hz = e;
        @(negedge clk);
        mode = 1'b0; select = 1'b0; adjust = 1'b0; en1hz = 1'b0;
    endtask

    initial begin
        idle(3);
        chk("rst_vec", 32'(vec()), 32'(V_NORMAL));
        chk("rst_inc", 32'({sec_inc, min_inc, hour_inc}), 32'd0);
        n_rst = 1'b1;
        idle(10);
        chk("idle_vec", 32'(vec()), 32'(V_NORMAL));
        chk("idle_inc", 32'(n_sec + n_min + n_hour), 32'd0);

        step(1, 0, 0, 0);
        chk("mode_sec", 32'(vec()), 32'(V_SEC));
        step(0, 1, 0, 0);
        chk("sel_hour", 32'(vec()), 32'(V_HOUR));
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk("hour_inc_lat", 32'({sec_inc, min_inc, hour_inc}), 32'b001);
            idle(1);
            chk("hour_inc_wid", 32'(hour_inc), 32'd0);
            idle(3);
        end
        chk("hour_cnt", 32'(n_hour), 32'd3);
        chk("sec_min_cnt", 32'(n_sec + n_min), 32'd0);
        chk("hour_still", 32'(vec()), 32'(V_HOUR));
        @(negedge clk) sig2hz = 1'b1;
        @(negedge clk);
        chk("blink_hi", 32'(vec()), 32'b1111);
        @(negedge clk) sig2hz = 1'b0;
        @(negedge clk);
        chk("blink_lo", 32'(vec()), 32'(V_HOUR));

        step(1, 0, 0, 0);
        chk("mode_exit", 32'(vec()), 32'(V_NORMAL));
        step(0, 1, 0, 0);
        chk("sel_normal", 32'(vec()), 32'(V_NORMAL));
        step(0, 0, 1, 0);
        idle(2);
        chk("adj_normal", 32'(n_sec + n_min + n_hour), 32'd3);
        step(1, 0, 1, 0);
        chk("mode_adj_sec", 32'(vec()), 32'(V_SEC));
        idle(2);
        chk("mode_adj_noinc", 32'(n_sec), 32'd0);
        step(0, 1, 0, 0);
        chk("cyc_hour", 32'(vec()), 32'(V_HOUR));
        step(0, 1, 0, 0);
        chk("cyc_min", 32'(vec()), 32'(V_MIN));
        step(0, 1, 0, 0);
        chk("cyc_sec", 32'(vec()), 32'(V_SEC));
        step(0, 1, 1, 0);
        idle(2);
        chk("sel_adj_hour", 32'(vec()), 32'(V_HOUR));
        chk("sel_adj_noinc", 32'(n_sec + n_min + n_hour), 32'd3);
        step(1, 0, 0, 0);
        chk("back_normal", 32'(vec()), 32'(V_NORMAL));

`ifdef ADJ_TIMEOUT_EN
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 1);
        idle(2);
        chk("tmo_pre", 32'(vec()), 32'(V_SEC));
        step(0, 0, 0, 1);
        chk("tmo_hit", 32'(vec()), 32'(V_NORMAL));
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("tmo_cancel", 32'(vec()), 32'(V_SEC));
        chk("tmo_cancel_inc", 32'(sec_inc), 32'd1);
        idle(2);
        chk("tmo_sec_cnt", 32'(n_sec), 32'd1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("tmo_restart_pre", 32'(vec()), 32'(V_SEC));
        step(0, 0, 0, 1);
        chk("tmo_restart_hit", 32'(vec()), 32'(V_NORMAL));
`else
        step(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1);
        chk("no_tmo", 32'(vec()), 32'(V_SEC));
        step(1, 0, 0, 0);
        chk("no_tmo_exit", 32'(vec()), 32'(V_NORMAL));
`endif

        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("pre_rst_min", 32'(vec()), 32'(V_MIN));
        @(negedge clk);
        adjust = 1'b1;
        n_rst = 1'b0;
        #1;
        chk("arst_vec", 32'(vec()), 32'(V_NORMAL));
        chk("arst_inc", 32'({sec_inc, min_inc, hour_inc}), 32'd0);
        @(negedge clk) adjust = 1'b0;
        idle(2);
        n_rst = 1'b1;
        idle(4);
        chk("post_rst_min", 32'(n_min), 32'd0);
        chk("post_rst_vec", 32'(vec()), 32'(V_NORMAL));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
